// File: rtl/control_cmd_dispatch_pkg.sv
// Shared types for the command dispatcher: FSM states, command indices and opcode decode.
package control_cmd_dispatch_pkg;

    localparam int CMD_INDEX_W = 3;

    typedef logic [CMD_INDEX_W-1:0] cmd_index_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_FORWARD,
        S_GAP
    } dispatch_state_t;

    typedef struct packed {
        logic       valid;
        cmd_index_t index;
    } cmd_decode_t;

    localparam logic [7:0] OPCODE_CLEAR    = 8'h43;
    localparam logic [7:0] OPCODE_BLANK    = 8'h5A;
    localparam logic [7:0] OPCODE_PIXEL    = 8'h50;
    localparam logic [7:0] OPCODE_FILLRECT = 8'h46;
    localparam logic [7:0] OPCODE_LINE     = 8'h4C;
    localparam logic [7:0] OPCODE_SCROLL   = 8'h53;
    localparam logic [7:0] OPCODE_TEXT     = 8'h54;
    localparam logic [7:0] OPCODE_PALETTE  = 8'h51;

    function automatic cmd_decode_t decode_opcode(input logic [7:0] opcode);
        cmd_decode_t result;
        result.valid = 1'b1;
        result.index = '0;
        case (opcode)
            OPCODE_CLEAR:    result.index = 3'd0;
            OPCODE_BLANK:    result.index = 3'd1;
            OPCODE_PIXEL:    result.index = 3'd2;
            OPCODE_FILLRECT: result.index = 3'd3;
            OPCODE_LINE:     result.index = 3'd4;
            OPCODE_SCROLL:   result.index = 3'd5;
            OPCODE_TEXT:     result.index = 3'd6;
            OPCODE_PALETTE:  result.index = 3'd7;
            default:         result.valid = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/control_cmd_dispatch_byte_fifo.sv
// Byte FIFO with registered read data; a push while full is rejected even if a pop happens.
module control_cmd_dispatch_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes a full FIFO from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            pop_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                pop_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/control_cmd_dispatch.sv
// Buffers UART bytes, decodes an opcode and forwards the payload to one command block.
// Define CONTROL_CMD_DISPATCH_TIMEOUT_EN to add the watchdog that aborts a stuck command.
module control_cmd_dispatch
    import control_cmd_dispatch_pkg::*;
#(
    parameter int NUM_CMDS       = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic [NUM_CMDS-1:0]         cmd_ready,
    input  logic [NUM_CMDS-1:0]         cmd_done,
    output logic [NUM_CMDS-1:0]         cmd_enable,
    output logic [7:0]                  data_out,
    output logic                        busy,
    output logic [$clog2(NUM_CMDS)-1:0] active_cmd,
    output logic                        overflow,
    output logic [7:0]                  bad_opcode_count,
    output logic                        cmd_abort
);
    localparam int IDX_W = $clog2(NUM_CMDS);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (NUM_CMDS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("NUM_CMDS and TIMEOUT_CYCLES must both be at least 2");
    end

    dispatch_state_t  state;
    dispatch_state_t  next_state;
    logic [IDX_W-1:0] sel;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    cmd_decode_t      decoded;
    logic             opcode_ok;
    logic             in_cmd;
    logic             done_sel;
    logic             ready_sel;
    logic             timeout;

    assign fifo_push = rx_valid && !fifo_full;
    assign decoded   = decode_opcode(fifo_rd_data);
    assign opcode_ok = decoded.valid && (int'(decoded.index) < NUM_CMDS);
    assign in_cmd    = (state == S_FORWARD) || (state == S_GAP);
    assign done_sel  = cmd_done[sel];
    assign ready_sel = cmd_ready[sel];

    control_cmd_dispatch_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (timeout),
        .push     (fifo_push),
        .push_data(rx_data),
        .pop      (fifo_pop),
        .pop_data (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef CONTROL_CMD_DISPATCH_TIMEOUT_EN
    logic [31:0] wd_count;

    // Restarts whenever a byte is handed over, so only a silent command times out.
    always_ff @(posedge clk) begin
        if (!reset_n || !in_cmd || state == S_GAP) begin
            wd_count <= '0;
        end else begin
            wd_count <= wd_count + 32'd1;
        end
    end

    assign timeout = in_cmd && !done_sel && (wd_count == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    assign cmd_abort = timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = opcode_ok ? S_FORWARD : S_IDLE;
            end
            S_FORWARD: begin
                if (done_sel || timeout) begin
                    next_state = S_IDLE;
                end else if (!fifo_empty && ready_sel) begin
                    fifo_pop   = 1'b1;
                    next_state = S_GAP;
                end
            end
            S_GAP: begin
                next_state = (done_sel || timeout) ? S_IDLE : S_FORWARD;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // The byte popped in S_FORWARD is presented during S_GAP, one cycle after the pop.
    always_comb begin
        cmd_enable = '0;
        data_out   = '0;
        busy       = 1'b0;
        active_cmd = '0;
        if (in_cmd) begin
            busy       = 1'b1;
            active_cmd = sel;
        end
        if (state == S_GAP) begin
            cmd_enable[sel] = 1'b1;
            data_out        = fifo_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sel              <= '0;
            overflow         <= 1'b0;
            bad_opcode_count <= '0;
        end else begin
            if (rx_valid && fifo_full) begin
                overflow <= 1'b1;
            end
            if (state == S_DECODE) begin
                if (opcode_ok) begin
                    sel <= IDX_W'(decoded.index);
                end else if (bad_opcode_count != 8'hFF) begin
                    bad_opcode_count <= bad_opcode_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Scoreboard bench for control_cmd_dispatch; forwarded bytes are checked against a queue of expectations.
module tb_control_cmd_dispatch;

    localparam int NUM_CMDS       = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int TIMEOUT_CYCLES = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_ready;
    logic [7:0] cmd_done;
    logic [7:0] cmd_enable;
    logic [7:0] data_out;
    logic       busy;
    logic [2:0] active_cmd;
    logic       overflow;
    logic [7:0] bad_opcode_count;
    logic       cmd_abort;

    typedef struct {
        logic [7:0] data;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   fwd_count = 0;
    int   cycle = 0;
    int   last_enable_cycle = 0;
    int   abort_count = 0;
    int   abort_cycle = 0;

    control_cmd_dispatch #(
        .NUM_CMDS      (NUM_CMDS),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .cmd_ready       (cmd_ready),
        .cmd_done        (cmd_done),
        .cmd_enable      (cmd_enable),
        .data_out        (data_out),
        .busy            (busy),
        .active_cmd      (active_cmd),
        .overflow        (overflow),
        .bad_opcode_count(bad_opcode_count),
        .cmd_abort       (cmd_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Consumer side of the scoreboard: every enable pops and checks one expectation.
    task automatic run_monitor();
        logic       prev_en;
        logic [7:0] want_en;
        exp_t       e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_abort === 1'b1) begin
                abort_count++;
                abort_cycle = cycle;
            end
            if (cmd_enable !== 8'h00 && cmd_enable !== 8'hxx) begin
                fwd_count++;
                last_enable_cycle = cycle;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_enable: got enable=%b data=%h, required no enable",
                             cmd_enable, data_out);
                end else begin
                    e = exp_q.pop_front();
                    want_en = 8'b1 << e.idx;
                    if (cmd_enable !== want_en || data_out !== e.data) begin
                        failures++;
                        $display("[TB] FAIL forward_byte: got enable=%b data=%h, required enable=%b data=%h",
                                 cmd_enable, data_out, want_en, e.data);
                    end
                end
                checks++;
                if (prev_en) begin
                    failures++;
                    $display("[TB] FAIL enable_spacing: got enables on consecutive cycles, required >=2 clk apart");
                end
            end
            prev_en = (cmd_enable !== 8'h00);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        cmd_ready = 8'h00;
        cmd_done  = 8'h00;
        tick(3);
        reset_n = 1'b1;
        exp_q.delete();
        tick(1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_done(input int idx);
        cmd_done = 8'b1 << idx;
        tick(1);
        cmd_done = 8'h00;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: got %0d bytes still pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        cmd_ready = 8'hFF;
        cmd_done  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            rx_data  = 8'h46;
            rx_valid = (i != 1);
            tick(1);
        end
        rx_valid = 1'b0;
        checks++; if (cmd_enable !== 8'h00) begin failures++; $display("[TB] FAIL reset_enable: got %b, required 0", cmd_enable); end
        checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h, required 00", data_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        checks++; if (active_cmd !== 3'd0) begin failures++; $display("[TB] FAIL reset_active: got %0d, required 0", active_cmd); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b, required 0", overflow); end
        checks++; if (bad_opcode_count !== 8'd0) begin failures++; $display("[TB] FAIL reset_badcount: got %0d, required 0", bad_opcode_count); end
        checks++; if (cmd_abort !== 1'b0) begin failures++; $display("[TB] FAIL reset_abort: got %b, required 0", cmd_abort); end
        reset_n = 1'b1;
        tick(4);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_fifo_empty_busy: got %b, required 0", busy); end
        checks++; if (active_cmd !== 3'd0) begin failures++; $display("[TB] FAIL reset_release_active: got %0d, required 0", active_cmd); end
        cmd_ready = 8'h00;
    endtask

    task automatic test_fillrect();
        logic [7:0] payload [8];
        payload = '{8'h00, 8'h05, 8'h03, 8'h00, 8'h0A, 8'h02, 8'h12, 8'h34};
        do_reset();
        cmd_ready = 8'h08;
        for (int i = 0; i < 8; i++) exp_q.push_back('{payload[i], 3});
        send_byte(8'h46);
        for (int i = 0; i < 8; i++) send_byte(payload[i]);
        wait_drain("fillrect_drain", 100);
        checks++; if (busy !== 1'b1 || active_cmd !== 3'd3) begin failures++; $display("[TB] FAIL fillrect_busy: got busy=%b active=%0d, required busy=1 active=3", busy, active_cmd); end
        pulse_done(5);
        tick(2);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL other_done_ignored: got busy=%b, required 1", busy); end
        pulse_done(3);
        checks++; if (busy !== 1'b0 || active_cmd !== 3'd0) begin failures++; $display("[TB] FAIL fillrect_done: got busy=%b active=%0d, required busy=0 active=0", busy, active_cmd); end
        cmd_ready = 8'h02;
        exp_q.push_back('{8'h99, 1});
        send_byte(8'h5A);
        send_byte(8'h99);
        wait_drain("next_opcode_drain", 50);
        checks++; if (busy !== 1'b1 || active_cmd !== 3'd1) begin failures++; $display("[TB] FAIL next_opcode: got busy=%b active=%0d, required busy=1 active=1", busy, active_cmd); end
        pulse_done(1);
    endtask

    task automatic test_bad_opcode();
        do_reset();
        send_byte(8'hFF);
        tick(3);
        checks++; if (bad_opcode_count !== 8'd1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bad_opcode_one: got count=%0d busy=%b, required count=1 busy=0", bad_opcode_count, busy); end
        send_byte(8'h5A);
        tick(3);
        checks++; if (active_cmd !== 3'd1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL after_bad_valid: got active=%0d busy=%b, required active=1 busy=1", active_cmd, busy); end
        pulse_done(1);
        do_reset();
        for (int i = 0; i < 255; i++) begin
            send_byte(8'hFF);
            tick(2);
        end
        tick(2);
        checks++; if (bad_opcode_count !== 8'd255) begin failures++; $display("[TB] FAIL bad_count_255: got %0d, required 255", bad_opcode_count); end
        send_byte(8'hFF);
        tick(3);
        checks++; if (bad_opcode_count !== 8'd255) begin failures++; $display("[TB] FAIL bad_count_saturate: got %0d, required 255", bad_opcode_count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL bad_no_overflow: got %b, required 0", overflow); end
    endtask

    task automatic test_overflow();
        int start_fwd;
        do_reset();
        send_byte(8'h46);
        tick(3);
        checks++; if (busy !== 1'b1 || active_cmd !== 3'd3) begin failures++; $display("[TB] FAIL ovf_opcode: got busy=%b active=%0d, required busy=1 active=3", busy, active_cmd); end
        for (int i = 0; i < 16; i++) exp_q.push_back('{8'(8'h10 + i), 3});
        for (int i = 0; i < 17; i++) send_byte(8'(8'h10 + i));
        tick(1);
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL overflow_set: got %b, required 1", overflow); end
        start_fwd = fwd_count;
        cmd_ready = 8'h08;
        wait_drain("overflow_drain", 200);
        tick(10);
        checks++; if (fwd_count - start_fwd != 16) begin failures++; $display("[TB] FAIL overflow_count: got %0d forwarded, required 16", fwd_count - start_fwd); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow); end
        pulse_done(3);
        tick(3);
        checks++; if (busy !== 1'b0 || bad_opcode_count !== 8'd0) begin failures++; $display("[TB] FAIL overflow_fifo_empty: got busy=%b count=%0d, required busy=0 count=0", busy, bad_opcode_count); end
    endtask

    task automatic test_done_race();
        do_reset();
        cmd_ready = 8'h08;
        send_byte(8'h46);
        tick(3);
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL race_busy: got %b, required 1", busy); end
        send_byte(8'h5A);
        pulse_done(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL race_done_priority: got busy=%b, required 0", busy); end
        tick(3);
        checks++; if (busy !== 1'b1 || active_cmd !== 3'd1 || bad_opcode_count !== 8'd0) begin failures++; $display("[TB] FAIL race_pending_opcode: got busy=%b active=%0d count=%0d, required 1/1/0", busy, active_cmd, bad_opcode_count); end
        pulse_done(1);
    endtask

    task automatic test_timeout();
        int start_abort;
        do_reset();
        cmd_ready = 8'h08;
        exp_q.push_back('{8'h77, 3});
        send_byte(8'h46);
        send_byte(8'h77);
        wait_drain("timeout_drain", 50);
        cmd_ready   = 8'h00;
        start_abort = abort_count;
        send_byte(8'h55);
        send_byte(8'h66);
`ifdef CONTROL_CMD_DISPATCH_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (abort_count == start_abort && n < 300) begin
                tick(1);
                n++;
            end
        end
        checks++; if (abort_count - start_abort != 1) begin failures++; $display("[TB] FAIL timeout_abort: got %0d pulses, required 1", abort_count - start_abort); end
        checks++; if (abort_cycle - last_enable_cycle != TIMEOUT_CYCLES) begin failures++; $display("[TB] FAIL timeout_latency: got %0d clk, required %0d", abort_cycle - last_enable_cycle, TIMEOUT_CYCLES); end
        tick(4);
        checks++; if (busy !== 1'b0 || bad_opcode_count !== 8'd0) begin failures++; $display("[TB] FAIL timeout_flush: got busy=%b count=%0d, required busy=0 count=0", busy, bad_opcode_count); end
`else
        tick(200);
        checks++; if (busy !== 1'b1 || active_cmd !== 3'd3) begin failures++; $display("[TB] FAIL no_timeout_busy: got busy=%b active=%0d, required busy=1 active=3", busy, active_cmd); end
        checks++; if (abort_count != start_abort) begin failures++; $display("[TB] FAIL no_timeout_abort: got %0d pulses, required 0", abort_count - start_abort); end
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        cmd_ready = 8'h00;
        cmd_done  = 8'h00;
        fork
            run_monitor();
        join_none
        test_reset();
        test_fillrect();
        test_bad_opcode();
        test_overflow();
        test_done_race();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
